// File: rtl/ascii_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the number-to-ASCII streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   ASCII_ZERO / ASCII_A / ASCII_CR / ASCII_LF / ASCII_QMARK  character constants
//   state_t                                                    serializer FSM states
//   hex_digits()                                               nibble count for a given width
//   dec_fits()                                                 true when DIGITS decimal slots hold 2**W-1
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        LOAD    = 3'd2,
        EMIT    = 3'd3,
        TERM_CR = 3'd4,
        TERM_LF = 3'd5
    } state_t;

    // Number of hex nibbles needed to print a w-bit value.
    function automatic int hex_digits(input int w);
        return (w + 3) / 4;
    endfunction

    // 10**d > 2**w - 1 ? Evaluated with 64-bit arithmetic; the loop stops as
    // soon as the power of ten exceeds the maximum value so it cannot overflow.
    function automatic bit dec_fits(input int w, input int d);
        longint unsigned maxv;
        longint unsigned p;
        maxv = (64'd1 << w) - 64'd1;
        p    = 64'd1;
        for (int i = 0; i < d && p <= maxv; i++) begin
            p = p * 64'd10;
        end
        return (p > maxv);
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps one 4-bit digit to its ASCII character; decimal digits as '0'-'9', hex digits 10-15 as 'A'-'F'.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   digit  in  4  digit value to print
//   hex    in  1  1: digits 10-15 are legal hex letters; 0: decimal, 10-15 print '?'
//   ascii  out 8  ASCII character
module nibble_to_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       hex,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_QMARK;
        case (digit) inside
            [4'd0:4'd9]:   ascii = ASCII_ZERO + {4'h0, digit};
            // A decimal conversion can never produce 10-15, so a '?' here
            // flags a corrupted digit rather than printing a bogus letter.
            [4'd10:4'd15]: ascii = hex ? (ASCII_A + {4'h0, digit - 4'd10}) : ASCII_QMARK;
            default:       ascii = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/ascii_num_serializer.sv
// Converts one unsigned value to a decimal (double dabble) or hex ASCII string, one char per handshake.
// Latency: first char DATA_W+1 cycles after accept (decimal), 2 cycles (hex); then one char per cycle.
// Backpressure: out_ready low holds out_char/out_last; in_ready stays low until the last char transfers.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   in_valid   in   1       value present on in_data/in_hex
//   in_ready   out  1       block idle, will accept (registered)
//   in_data    in   DATA_W  unsigned value to print
//   in_hex     in   1       1: hex, 0: decimal (sampled at accept; ignored when HEX_EN=0)
//   out_valid  out  1       out_char valid
//   out_ready  in   1       sink accepts out_char
//   out_char   out  8       ASCII character
//   out_last   out  1       final char of the string
//   busy       out  1       conversion/emission in progress
module ascii_num_serializer
    import ascii_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIGITS  = 5,
    parameter int HEX_EN  = 1,
    parameter int LZ_SUP  = 1,
    parameter int TERM_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_hex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy
);

    localparam int HEX_D = hex_digits(DATA_W);
    // One digit-slot array serves both radices, so size it for whichever needs more.
    localparam int NSLOT = (DIGITS > HEX_D) ? DIGITS : HEX_D;
    // Binary part in the low DATA_W bits, BCD slots above it. Slots beyond
    // DIGITS stay zero through the conversion (0 is never adjusted).
    localparam int SRW   = DATA_W + 4 * NSLOT;
    localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CW    = $clog2(DATA_W);

    if (DATA_W < 4) begin : g_width_err
        $error("ascii_num_serializer: DATA_W must be at least 4");
    end
    if (!dec_fits(DATA_W, DIGITS)) begin : g_digits_err
        $error("ascii_num_serializer: DIGITS too small to print 2**DATA_W-1");
    end

    state_t          state_q, state_d;
    logic [SRW-1:0]  sr_q;
    logic [SRW-1:0]  sr_adj;
    logic [SRW-1:0]  sr_dd;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_first;
    logic [IW-1:0]   ndig_m1;
    logic [4*NSLOT-1:0] fin_digits;
    logic [3:0]      cur_dig;
    logic [7:0]      dig_char;
    logic            hex_q;
    logic            in_ready_q;
    logic            accept;
    logic            xfer;
    logic            last_conv;
    logic            at_lsd;

    //------------------------------------------------------------------
    // Handshake qualifiers
    //------------------------------------------------------------------
    assign accept    = in_valid && in_ready_q && (state_q == IDLE);
    assign xfer      = out_valid && out_ready;
    assign last_conv = (state_q == CONV) && (cnt_q == CW'(DATA_W - 1));
    assign at_lsd    = (idx_q == '0);
    assign in_ready  = in_ready_q;

    //------------------------------------------------------------------
    // Double dabble step: add 3 to every BCD slot >= 5, then shift left.
    //------------------------------------------------------------------
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NSLOT; i++) begin
            if (sr_q[DATA_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[DATA_W + 4*i +: 4] = sr_q[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_dd = {sr_adj[SRW-2:0], 1'b0};
    end

    // Final digit vector at the CONV/LOAD exit edge. Decimal reads the
    // post-shift value because the last shift lands on that same edge; hex
    // reads the raw zero-extended value already sitting in the low bits.
    assign fin_digits = hex_q ? sr_q[4*NSLOT-1:0] : sr_dd[SRW-1 -: 4*NSLOT];
    assign ndig_m1    = hex_q ? IW'(HEX_D - 1) : IW'(DIGITS - 1);

    //------------------------------------------------------------------
    // Leading-digit encoder: highest nonzero slot within the active radix,
    // LSD when the value is zero, MSD when suppression is disabled. Starting
    // the pointer here means skipped zeros cost no cycles.
    //------------------------------------------------------------------
    always_comb begin
        idx_first = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if ((IW'(i) <= ndig_m1) && (fin_digits[4*i +: 4] != 4'd0)) begin
                idx_first = IW'(i);
            end
        end
        if (LZ_SUP == 0) begin
            idx_first = ndig_m1;
        end
    end

    //------------------------------------------------------------------
    // Digit under the pointer, taken from whichever region holds it.
    //------------------------------------------------------------------
    always_comb begin
        cur_dig = 4'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (IW'(i) == idx_q) begin
                cur_dig = hex_q ? sr_q[4*i +: 4] : sr_q[DATA_W + 4*i +: 4];
            end
        end
    end

    nibble_to_ascii u_n2a (
        .digit (cur_dig),
        .hex   (hex_q),
        .ascii (dig_char)
    );

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ((HEX_EN != 0) && in_hex) ? LOAD : CONV;
                end
            end
            CONV: begin
                if (last_conv) begin
                    state_d = EMIT;
                end
            end
            LOAD: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (xfer && at_lsd) begin
                    state_d = (TERM_EN != 0) ? TERM_CR : IDLE;
                end
            end
            TERM_CR: begin
                if (xfer) begin
                    state_d = TERM_LF;
                end
            end
            TERM_LF: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs. Everything decodes from registered state so an async
    // reset drops the stream in the same cycle.
    //------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_char  = 8'h00;
        out_last  = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            EMIT: begin
                out_valid = 1'b1;
                out_char  = dig_char;
                out_last  = at_lsd && (TERM_EN == 0);
            end
            TERM_CR: begin
                out_valid = 1'b1;
                out_char  = ASCII_CR;
            end
            TERM_LF: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath: shift register, shift counter, digit pointer, radix flag.
    // in_ready is registered from the next state, so it rises on the first
    // edge after reset release and the edge after the final transfer.
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            hex_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d == IDLE);
            if (accept) begin
                sr_q  <= SRW'(in_data);
                cnt_q <= '0;
                hex_q <= (HEX_EN != 0) && in_hex;
            end else begin
                case (state_q)
                    CONV: begin
                        sr_q  <= sr_dd;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_conv) begin
                            idx_q <= idx_first;
                        end
                    end
                    LOAD: begin
                        idx_q <= idx_first;
                    end
                    EMIT: begin
                        if (xfer && !at_lsd) begin
                            idx_q <= idx_q - IW'(1);
                        end
                    end
                    default: begin
                        idx_q <= idx_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascii_num_serializer.sv
// Bench: two serializers share one input stream (LZ_SUP=1 and LZ_SUP=0); a string model predicts both.
// Latency: first-char delay measured against DATA_W (decimal) and 1 (hex) edges after accept.
// Backpressure: a stall on out_ready must hold the character; a scoreboard checks every transfer.
module tb_ascii_num_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_hex = 1'b0;
    logic        out_ready = 1'b1;

    logic        ir [2];
    logic        ov [2];
    logic        ol [2];
    logic        bz [2];
    logic [7:0]  oc [2];

    int errors = 0;
    int checks = 0;

    logic [8:0]  q [2][$];
    string       cap [2];
    logic        stall [2];
    logic [8:0]  held [2];
    logic [8:0]  exp_v [2];

    always #5 clk = ~clk;

    ascii_num_serializer #(.DATA_W(16), .DIGITS(5), .HEX_EN(1), .LZ_SUP(1), .TERM_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_hex(in_hex), .out_valid(ov[0]), .out_ready(out_ready), .out_char(oc[0]),
        .out_last(ol[0]), .busy(bz[0]));

    ascii_num_serializer #(.DATA_W(16), .DIGITS(5), .HEX_EN(1), .LZ_SUP(0), .TERM_EN(1)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_hex(in_hex), .out_valid(ov[1]), .out_ready(out_ready), .out_char(oc[1]),
        .out_last(ol[1]), .busy(bz[1]));

    //------------------------------------------------------------------
    // Helpers
    //------------------------------------------------------------------
    function automatic string crlf(input string s);
        return $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
    endfunction

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == 8'h0D)      r = {r, "<CR>"};
            else if (s.getc(i) == 8'h0A) r = {r, "<LF>"};
            else                         r = $sformatf("%s%c", r, s.getc(i));
        end
        return r;
    endfunction

    // Expected string by plain radix arithmetic: fixed-width digits, then
    // optionally strip leading '0's (keeping at least one), then CR LF.
    function automatic string model_str(input int unsigned v, input bit hex, input bit lz);
        string s;
        string tbl;
        int unsigned base;
        int unsigned n;
        tbl  = "0123456789ABCDEF";
        s    = "";
        base = hex ? 16 : 10;
        n    = hex ? 4 : 5;
        for (int i = 0; i < int'(n); i++) begin
            s = $sformatf("%c%s", tbl.getc(int'(v % base)), s);
            v = v / base;
        end
        if (lz) begin
            while (s.len() > 1 && s.getc(0) == 8'h30) s = s.substr(1, s.len() - 1);
        end
        return crlf(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(expv));
        end
    endtask

    task automatic push_model(input int unsigned v, input bit hex);
        string s0;
        string s1;
        s0 = model_str(v, hex, 1'b1);
        s1 = model_str(v, hex, 1'b0);
        for (int i = 0; i < s0.len(); i++) q[0].push_back({i == s0.len() - 1, s0.getc(i)});
        for (int i = 0; i < s1.len(); i++) q[1].push_back({i == s1.len() - 1, s1.getc(i)});
    endtask

    //------------------------------------------------------------------
    // Scoreboard: every transfer must match the model queue, and a stalled
    // character must still be presented unchanged on the next cycle.
    //------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                stall[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (stall[d]) begin
                    chk($sformatf("hold dut%0d", d), {23'd0, ov[d], ol[d], oc[d]}, {23'd0, 1'b1, held[d]});
                end
                if (ov[d]) begin
                    if (out_ready) begin
                        stall[d] = 1'b0;
                        cap[d]   = $sformatf("%s%c", cap[d], oc[d]);
                        if (q[d].size() == 0) begin
                            chk($sformatf("extra char dut%0d", d), {23'd0, ol[d], oc[d]}, 32'h1FF);
                        end else begin
                            exp_v[d] = q[d].pop_front();
                            chk($sformatf("char dut%0d", d), {23'd0, ol[d], oc[d]}, {23'd0, exp_v[d]});
                        end
                    end else begin
                        stall[d] = 1'b1;
                        held[d]  = {ol[d], oc[d]};
                    end
                end else begin
                    stall[d] = 1'b0;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Stimulus tasks
    //------------------------------------------------------------------
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (ir[0] && ir[1] && q[0].size() == 0 && q[1].size() == 0) ok = 1'b1;
        end
        chk("idle timeout", {31'd0, ok}, 32'd1);
    endtask

    // Presents one value, then returns at the negedge where dut first shows
    // out_valid; lat is the number of edges from the accept edge to that point.
    task automatic send(input logic [15:0] v, input bit hex, output int lat);
        lat = -1;
        wait_idle();
        cap[0] = "";
        cap[1] = "";
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = v;
        in_hex   = hex;
        push_model(v, hex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("busy after accept", {31'd0, bz[0]}, 32'd1);
                chk("in_ready after accept", {31'd0, ir[0]}, 32'd0);
            end
            if (ov[0]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run(input logic [15:0] v, input bit hex, input int exp_lat, input string exp_a);
        int lat;
        send(v, hex, lat);
        chk($sformatf("latency %0h", v), lat, exp_lat);
        wait_idle();
        chk_str($sformatf("string %0h", v), cap[0], exp_a);
    endtask

    //------------------------------------------------------------------
    // Main sequence
    //------------------------------------------------------------------
    initial begin
        int  lat;
        bit  found;

        for (int d = 0; d < 2; d++) begin
            stall[d] = 1'b0;
            cap[d]   = "";
        end

        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready", {31'd0, ir[d]}, 32'd0);
            chk("reset out_valid", {31'd0, ov[d]}, 32'd0);
            chk("reset out_char", {24'd0, oc[d]}, 32'd0);
            chk("reset out_last", {31'd0, ol[d]}, 32'd0);
            chk("reset busy", {31'd0, bz[d]}, 32'd0);
        end

        // Pin the model against hand-written strings.
        chk_str("model 1234", model_str(1234, 1'b0, 1'b1), crlf("1234"));
        chk_str("model 0 nz", model_str(0, 1'b0, 1'b0), crlf("00000"));
        chk_str("model 00AF", model_str(16'h00AF, 1'b1, 1'b1), crlf("AF"));
        chk_str("model 00AF nz", model_str(16'h00AF, 1'b1, 1'b0), crlf("00AF"));

        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready before first edge", {31'd0, ir[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready after first edge", {31'd0, ir[0]}, 32'd1);

        run(16'd1234,  1'b0, 16, crlf("1234"));
        chk_str("nz 1234", cap[1], crlf("01234"));
        run(16'd0,     1'b0, 16, crlf("0"));
        chk_str("nz 0", cap[1], crlf("00000"));
        run(16'd65535, 1'b0, 16, crlf("65535"));
        run(16'h00AF,  1'b1, 1,  crlf("AF"));
        chk_str("nz 00AF", cap[1], crlf("00AF"));
        run(16'hBEEF,  1'b1, 1,  crlf("BEEF"));

        // Stall three cycles on '3' of 1234 with an in_valid pulse while busy.
        send(16'd1234, 1'b0, lat);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (ov[0] && oc[0] == 8'h32) found = 1'b1;
        end
        chk("stall found '2'", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd999;
        in_hex    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall char", {23'd0, ov[0], oc[0]}, {23'd0, 1'b1, 8'h33});
            if (i == 0) chk("in_ready while busy", {31'd0, ir[0]}, 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();
        chk_str("stall string", cap[0], crlf("1234"));

        // Reset in the middle of emission, then a clean string.
        send(16'd65535, 1'b0, lat);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            chk("midreset out_valid", {31'd0, ov[d]}, 32'd0);
            chk("midreset out_char", {24'd0, oc[d]}, 32'd0);
            chk("midreset busy", {31'd0, bz[d]}, 32'd0);
            chk("midreset in_ready", {31'd0, ir[d]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(16'd42, 1'b0, 16, crlf("42"));
        chk_str("nz 42", cap[1], crlf("00042"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run cannot hang.
    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
